// File: rtl/servo_pkg.sv
// Shared servo PWM constants and the position-to-pulse-width conversion,
// used by the capture logic and by anything that needs to predict pulse widths.
package servo_pkg;

   localparam int TICK_DIV_DEF     = 50;
   localparam int PERIOD_TICKS_DEF = 20000;
   localparam int MIN_TICKS_DEF    = 500;
   localparam int MAX_TICKS_DEF    = 2500;
   localparam int SCALE_DEF        = 8;
   localparam int POS_WIDTH_DEF    = 8;

   // Signed 32-bit math covers MIN + pos*SCALE + trim for any sane parameter set.
   function automatic int pos_to_ticks(input int pos, input int trim,
                                       input int min_ticks, input int max_ticks,
                                       input int scale);
      int raw;
      raw = min_ticks + pos * scale + trim;
      if (raw > max_ticks) begin
         raw = max_ticks;
      end else if (raw < min_ticks) begin
         raw = min_ticks;
      end
      return raw;
   endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Timebase for the servo PWM: clk prescaler to timer ticks, tick counter per
// frame, and the one-clock frame_start strobe.
module servo_tick_gen #(
   parameter  int TICK_DIV     = 50,
   parameter  int PERIOD_TICKS = 20000,
   localparam int PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
   localparam int TW           = $clog2(PERIOD_TICKS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          tick,
   output logic [TW-1:0] period_cnt,
   output logic          frame_start
);

   logic [PW-1:0] prescaler_q, prescaler_d;
   logic [TW-1:0] period_cnt_q, period_cnt_d;

   // NOTE: every signal gets a default before any branch, so no latch is inferred.
   always_comb begin
      tick         = (prescaler_q == PW'(TICK_DIV - 1));
      prescaler_d  = tick ? '0 : prescaler_q + 1'b1;
      period_cnt_d = period_cnt_q;
      if (tick) begin
         period_cnt_d = (period_cnt_q == TW'(PERIOD_TICKS - 1)) ? '0 : period_cnt_q + 1'b1;
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prescaler_q  <= '0;
         period_cnt_q <= '0;
      end else begin
         prescaler_q  <= prescaler_d;
         period_cnt_q <= period_cnt_d;
      end
   end

   assign period_cnt  = period_cnt_q;
   assign frame_start = rst & (prescaler_q == '0) & (period_cnt_q == '0);

endmodule

// File: rtl/servo_pwm_gen.sv
// Per-channel servo PWM generator: captures a position, applies it at the next
// frame boundary and drives a registered pulse. Define SERVO_PWM_TRIM_EN to add the trim input.
module servo_pwm_gen
   import servo_pkg::*;
#(
   parameter  int TICK_DIV     = TICK_DIV_DEF,
   parameter  int PERIOD_TICKS = PERIOD_TICKS_DEF,
   parameter  int MIN_TICKS    = MIN_TICKS_DEF,
   parameter  int MAX_TICKS    = MAX_TICKS_DEF,
   parameter  int SCALE        = SCALE_DEF,
   parameter  int POS_WIDTH    = POS_WIDTH_DEF,
   localparam int TW           = $clog2(PERIOD_TICKS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pos_valid,
   input  logic [POS_WIDTH-1:0] pos_in,
   input  logic                 servo_en,
`ifdef SERVO_PWM_TRIM_EN
   input  logic signed [7:0]    trim,
`endif
   output logic                 pwm_out,
   output logic                 frame_start,
   output logic                 pending
);

   logic [TW-1:0] period_cnt;
   logic          tick_unused;

   logic [TW-1:0] cap_ticks;
   logic [TW-1:0] pending_ticks_q, pending_ticks_d;
   logic [TW-1:0] active_ticks_q, active_ticks_d;
   logic          pending_q, pending_d;
   logic          pwm_q, pwm_d;

   servo_tick_gen #(
      .TICK_DIV     (TICK_DIV),
      .PERIOD_TICKS (PERIOD_TICKS)
   ) u_tick_gen (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick_unused),
      .period_cnt  (period_cnt),
      .frame_start (frame_start)
   );

   always_comb begin
`ifdef SERVO_PWM_TRIM_EN
      cap_ticks = TW'(pos_to_ticks(int'(pos_in), int'(trim), MIN_TICKS, MAX_TICKS, SCALE));
`else
      cap_ticks = TW'(pos_to_ticks(int'(pos_in), 0, MIN_TICKS, MAX_TICKS, SCALE));
`endif
      pending_ticks_d = pos_valid ? cap_ticks : pending_ticks_q;
      pending_d       = pending_q | pos_valid;
      active_ticks_d  = active_ticks_q;
      if (frame_start) begin
         pending_d = 1'b0;
         if (pos_valid) begin
            active_ticks_d = cap_ticks;
         end else if (pending_q) begin
            active_ticks_d = pending_ticks_q;
         end
      end
      // Compare against the width this frame will use, so a width loaded on
      // frame_start already governs the first pulse clock.
      pwm_d = servo_en & (period_cnt < active_ticks_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_ticks_q <= '0;
         active_ticks_q  <= '0;
         pending_q       <= 1'b0;
         pwm_q           <= 1'b0;
      end else begin
         pending_ticks_q <= pending_ticks_d;
         active_ticks_q  <= active_ticks_d;
         pending_q       <= pending_d;
         pwm_q           <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: frame-arithmetic reference model
// compared every cycle, plus directed frames with hand-computed pulse widths.
module tb_servo_pwm_gen;
   import servo_pkg::*;

   localparam int TD    = 4;
   localparam int PT    = 100;
   localparam int MINT  = 10;
   localparam int MAXT  = 40;
   localparam int SC    = 1;
   localparam int FRAME = TD * PT;

   logic              clk = 1'b0;
   logic              rst;
   logic              pos_valid;
   logic [7:0]        pos_in;
   logic              servo_en;
   logic signed [7:0] trim;
   logic              pwm_out;
   logic              frame_start;
   logic              pending;

   int n_checks = 0;
   int n_pass   = 0;

   servo_pwm_gen #(
      .TICK_DIV     (TD),
      .PERIOD_TICKS (PT),
      .MIN_TICKS    (MINT),
      .MAX_TICKS    (MAXT),
      .SCALE        (SC),
      .POS_WIDTH    (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pos_valid   (pos_valid),
      .pos_in      (pos_in),
      .servo_en    (servo_en),
`ifdef SERVO_PWM_TRIM_EN
      .trim        (trim),
`endif
      .pwm_out     (pwm_out),
      .frame_start (frame_start),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: ph counts clocks since reset release; the frame a clock
   // belongs to and its tick offset follow from plain division.
   int ph = 0;
   int m_pt = 0;
   int m_act = 0;
   bit m_pend = 0;
   bit m_pwm = 0;
   bit m_live = 0;

   always @(posedge clk) begin
      int cap;
      if (!rst) begin
         ph = 0; m_pt = 0; m_act = 0; m_pend = 0; m_pwm = 0; m_live = 1;
      end else begin
         cap = pos_to_ticks(int'(pos_in), int'(trim), MINT, MAXT, SC);
         if (ph % FRAME == 0) begin
            if (pos_valid) m_act = cap;
            else if (m_pend) m_act = m_pt;
            m_pend = 0;
         end else if (pos_valid) begin
            m_pt   = cap;
            m_pend = 1;
         end
         m_pwm = servo_en && (((ph % FRAME) / TD) < m_act);
         ph++;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("cyc_frame_start", int'(frame_start), int'(rst && (ph % FRAME == 0)));
         check("cyc_pwm_out", int'(pwm_out), int'(m_pwm));
         check("cyc_pending", int'(pending), int'(m_pend));
      end
   end

   // Runs one frame starting at the negedge of a frame_start clock; offsets k
   // are clocks after that frame_start. Ends at the next frame_start negedge.
   task automatic run_frame(input int s1, input int p1, input int s2, input int p2,
                            input int en_off, output int width, output int rise,
                            output int fall, output int pend1);
      width = 0; rise = 0; fall = 0; pend1 = 0;
      for (int k = 1; k <= FRAME; k++) begin
         @(posedge clk); #1;
         pos_valid = (s1 != 0 && k == s1) || (s2 != 0 && k == s2);
         pos_in    = (s2 != 0 && k == s2) ? 8'(p2) : 8'(p1);
         servo_en  = !(en_off != 0 && k >= en_off);
         @(negedge clk);
         if (k == 1) pend1 = int'(pending);
         if (pwm_out) begin
            width++;
            if (rise == 0) rise = k;
         end else if (rise != 0 && fall == 0) begin
            fall = k;
         end
      end
   endtask

   initial begin
      int w, r, f, p1;
      rst = 1'b0; pos_valid = 1'b0; pos_in = '0; servo_en = 1'b1; trim = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_frame_start", int'(frame_start), 0);
      check("rst_pending", int'(pending), 0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("first_frame_start", int'(frame_start), 1);

      // Idle frame: no position yet, so no pulse.
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("idle_width", w, 0);
      check("idle_period_fs", int'(frame_start), 1);
      check("idle_pending", int'(pending), 0);

      // Basic: pos 5 -> 15 ticks -> 60 clocks.
      run_frame(150, 5, 0, 0, 0, w, r, f, p1);
      check("basic_pending_held", int'(pending), 1);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("basic_pending_cleared", p1, 0);
      check("basic_width", w, 60);
      check("basic_rise", r, 1);
      check("basic_fall", f, 61);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("basic_repeat_width", w, 60);

      // Clamp: pos 200 -> 40 ticks -> 160 clocks.
      run_frame(100, 200, 0, 0, 0, w, r, f, p1);
      check("clamp_old_width", w, 60);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("clamp_width", w, 160);
      check("clamp_fall", f, 161);

      // Bypass: pos 0 strobed on the frame_start clock -> 10 ticks that frame.
      run_frame(0, 0, 0, 0, FRAME + 1, w, r, f, p1);
      run_frame(FRAME, 0, 0, 0, 0, w, r, f, p1);
      check("bypass_prev_width", w, 160);
      check("bypass_fs_aligned", int'(frame_start), 1);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("bypass_width", w, 40);
      check("bypass_pending", p1, 0);

      // Last wins: 3 then 20 -> 30 ticks -> 120 clocks.
      run_frame(50, 3, 250, 20, 0, w, r, f, p1);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("last_wins_width", w, 120);

      // Gating: servo_en low from clock 20 of a 160-clock pulse.
      run_frame(100, 200, 0, 0, 0, w, r, f, p1);
      run_frame(0, 0, 0, 0, 20, w, r, f, p1);
      check("gate_width", w, 20);
      check("gate_fall", f, 21);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);

      // Reset mid-pulse, then the output stays dark until a new position.
      repeat (10) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("pre_rst_pwm", int'(pwm_out), 1);
      @(negedge clk);
      check("rst_mid_pwm", int'(pwm_out), 0);
      check("rst_mid_pending", int'(pending), 0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("rel_frame_start", int'(frame_start), 1);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("dark_width_0", w, 0);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("dark_width_1", w, 0);
      run_frame(10, 5, 0, 0, 0, w, r, f, p1);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("post_rst_width", w, 60);

`ifdef SERVO_PWM_TRIM_EN
      // Trim saturates at both ends of [MIN_TICKS, MAX_TICKS].
      trim = -8'sd20;
      run_frame(10, 5, 0, 0, 0, w, r, f, p1);
      trim = 8'sd30;
      run_frame(10, 5, 0, 0, 0, w, r, f, p1);
      check("trim_neg_width", w, 40);
      run_frame(0, 0, 0, 0, 0, w, r, f, p1);
      check("trim_pos_width", w, 160);
      trim = '0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
